dup_adder78_ctrl: RTL and testbench

Sequencer and two-port arbiter for the 78-bit duplicated carry-select adder (s / s_invert dual-rail outputs). Two requesters share one adder instance through valid/ready handshakes. The controller computes the operand parities, drives the adder, and checks that s == ~s_invert. On a mismatch it retries, and it reports a sticky error count. The adder sits outside this block; the controller drives its operand/parity pins and samples its sum pins.

---
 rtl/dup_adder78_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dup_adder78_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dup_adder78_ctrl.sv
// dup_adder78_ctrl: sequencer and two-port round-robin arbiter for an external
// duplicated (dual-rail) carry-select adder. One operand pair is accepted at a
// time. The registered operands and their parities are driven to the adder, and
// the adder's s / s_invert pair is checked for complementarity. A mismatch is
// retried up to MAX_RETRY times before the result is flagged as an error.
//
// Handshake rule for every channel: a transfer happens on a rising clk edge where
// valid and ready are both 1. A producer holds valid and its payload stable until
// that transfer. reqN_ready depends combinationally on reqN_valid, and rsp_valid
// depends only on registered state.
module dup_adder78_ctrl #(
    parameter int WIDTH     = 78,
    parameter int MAX_RETRY = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_pa,
    output logic                 add_pb,
    input  logic [WIDTH-1:0]     add_s,
    input  logic [WIDTH-1:0]     add_s_inv,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_sum,
    output logic                 rsp_src,
    output logic                 rsp_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Retry limit narrowed to the counter width (legal range 0..3).
    localparam logic [1:0]           MAX_RETRY_L = 2'(MAX_RETRY);
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_ONE = ERR_CNT_W'(1);

    state_t                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic [1:0]             retry_q, retry_d;
    logic [WIDTH-1:0]       add_a_q, add_a_d;
    logic [WIDTH-1:0]       add_b_q, add_b_d;
    logic                   add_pa_q, add_pa_d;
    logic                   add_pb_q, add_pb_d;
    logic [WIDTH-1:0]       rsp_sum_q, rsp_sum_d;
    logic                   rsp_src_q, rsp_src_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic                   any_valid;
    logic                   grant_sel;
    logic                   accept;
    logic [WIDTH-1:0]       sel_a;
    logic [WIDTH-1:0]       sel_b;
    logic                   dual_ok;

    // Arbitration: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        grant_sel = req1_valid & (~req0_valid | ~last_grant_q);
        accept    = (state_q == ST_IDLE) & any_valid;
        sel_a     = grant_sel ? req1_a : req0_a;
        sel_b     = grant_sel ? req1_b : req0_b;
        dual_ok   = (add_s == ~add_s_inv);
    end

    // Next-state and datapath update for the IDLE -> ISSUE -> RESP sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        retry_d      = retry_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        add_pa_d     = add_pa_q;
        add_pb_d     = add_pb_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_src_d    = rsp_src_q;
        rsp_err_d    = rsp_err_q;
        err_cnt_d    = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // Parities are latched together with the operands so the
                    // adder always sees a consistent operand/parity set.
                    add_a_d      = sel_a;
                    add_b_d      = sel_b;
                    add_pa_d     = ^sel_a;
                    add_pb_d     = ^sel_b;
                    rsp_src_d    = grant_sel;
                    last_grant_d = grant_sel;
                    retry_d      = 2'd0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // The adder has had a full cycle to settle on the held operands.
                rsp_sum_d = add_s;
                if (dual_ok) begin
                    rsp_err_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (retry_q < MAX_RETRY_L) begin
                    retry_d = retry_q + 2'd1;
                end else begin
                    rsp_err_d = 1'b1;
                    if (err_cnt_q != ERR_CNT_MAX) begin
                        err_cnt_d = err_cnt_q + ERR_CNT_ONE;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            retry_q      <= 2'd0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            add_pa_q     <= 1'b0;
            add_pb_q     <= 1'b0;
            rsp_sum_q    <= '0;
            rsp_src_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            retry_q      <= retry_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            add_pa_q     <= add_pa_d;
            add_pb_q     <= add_pb_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_src_q    <= rsp_src_d;
            rsp_err_q    <= rsp_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Output drive: ready only while idle, one requester at a time.
    always_comb begin
        req0_ready = accept & ~grant_sel;
        req1_ready = accept & grant_sel;
        add_a      = add_a_q;
        add_b      = add_b_q;
        add_pa     = add_pa_q;
        add_pb     = add_pb_q;
        rsp_valid  = (state_q == ST_RESP);
        rsp_sum    = rsp_sum_q;
        rsp_src    = rsp_src_q;
        rsp_err    = rsp_err_q;
        err_cnt    = err_cnt_q;
    end

endmodule

// File: tb/tb_dup_adder78_ctrl.sv
// Bench for dup_adder78_ctrl: behavioural adder with injectable dual-rail
// faults, a transaction-level reference model (grant, latency, sum, error count)
// and directed plus randomized transactions.
module tb_dup_adder78_ctrl;
    localparam int W    = 78;
    localparam int MAXR = 1;
    localparam int CW   = 8;

    // Clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [W-1:0]  add_a, add_b, add_s, add_s_inv;
    logic          add_pa, add_pb;
    logic          rsp_valid, rsp_ready, rsp_src, rsp_err;
    logic [W-1:0]  rsp_sum;
    logic [CW-1:0] err_cnt;

    logic flip_bit5;
    logic force_eq;

    dup_adder78_ctrl #(.WIDTH(W), .MAX_RETRY(MAXR), .ERR_CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .add_a(add_a), .add_b(add_b), .add_pa(add_pa), .add_pb(add_pb),
        .add_s(add_s), .add_s_inv(add_s_inv),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
        .rsp_src(rsp_src), .rsp_err(rsp_err), .err_cnt(err_cnt)
    );

    // Behavioural duplicated adder with fault injection on the inverted rail.
    always_comb begin
        add_s = add_a + add_b;
        if (force_eq)       add_s_inv = add_s;
        else if (flip_bit5) add_s_inv = ~add_s ^ (W'(1) << 5);
        else                add_s_inv = ~add_s;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_last   = 1;
    int m_errcnt = 0;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic checkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_op();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    // One transaction from IDLE back to IDLE. fault: 0 none, 1 transient, 2 persistent.
    task automatic run_txn(input logic v0, input logic v1,
                           input logic [W-1:0] a0, input logic [W-1:0] b0,
                           input logic [W-1:0] a1, input logic [W-1:0] b1,
                           input int fault, input int hold);
        logic         g;
        logic [W-1:0] ea, eb, esum;
        logic         eerr;
        int           exp_lat;
        int           cycles;
        // Reference model: round-robin grant, wrapped sum, retry-driven latency.
        if (v0 && v1) g = (m_last == 1) ? 1'b0 : 1'b1;
        else          g = v0 ? 1'b0 : 1'b1;
        ea      = g ? a1 : a0;
        eb      = g ? b1 : b0;
        esum    = ea + eb;
        eerr    = (fault == 2);
        exp_lat = 2 + ((fault == 1) ? 1 : ((fault == 2) ? MAXR : 0));
        m_last  = int'(g);
        if (eerr && m_errcnt < 255) m_errcnt++;

        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        flip_bit5  = (fault == 1);
        force_eq   = (fault == 2);
        rsp_ready  = (hold == 0);
        #1;
        check1("req0_ready_grant", req0_ready, ~g);
        check1("req1_ready_grant", req1_ready, g);

        @(negedge clk);
        cycles = 1;
        checkw("add_a", add_a, ea);
        checkw("add_b", add_b, eb);
        check1("add_pa", add_pa, ^ea);
        check1("add_pb", add_pb, ^eb);
        check1("req0_ready_busy", req0_ready, 1'b0);
        check1("req1_ready_busy", req1_ready, 1'b0);
        check1("rsp_valid_early", rsp_valid, 1'b0);

        while (!rsp_valid && cycles < 10) begin
            @(negedge clk);
            cycles++;
            flip_bit5 = 1'b0;
        end
        check1("rsp_valid_timeout", rsp_valid, 1'b1);
        checkw("latency", W'(cycles), W'(exp_lat));
        checkw("rsp_sum", rsp_sum, esum);
        check1("rsp_src", rsp_src, g);
        check1("rsp_err", rsp_err, eerr);
        checkw("err_cnt", W'(err_cnt), W'(m_errcnt));

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check1("hold_rsp_valid", rsp_valid, 1'b1);
            checkw("hold_rsp_sum", rsp_sum, esum);
            check1("hold_rsp_src", rsp_src, g);
            check1("hold_rsp_err", rsp_err, eerr);
            check1("hold_req0_ready", req0_ready, 1'b0);
            check1("hold_req1_ready", req1_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check1("rsp_valid_drop", rsp_valid, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        force_eq   = 1'b0;
        flip_bit5  = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] half;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1; flip_bit5 = 1'b0; force_eq = 1'b0;
        ones = '1;
        half = W'(1) << 77;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check1("rst_rsp_valid", rsp_valid, 1'b0);
        checkw("rst_rsp_sum", rsp_sum, '0);
        check1("rst_rsp_src", rsp_src, 1'b0);
        check1("rst_rsp_err", rsp_err, 1'b0);
        checkw("rst_err_cnt", W'(err_cnt), '0);
        checkw("rst_add_a", add_a, '0);
        checkw("rst_add_b", add_b, '0);
        check1("rst_add_pa", add_pa, 1'b0);
        check1("rst_add_pb", add_pb, 1'b0);
        check1("rst_req0_ready", req0_ready, 1'b0);

        // Basic
        run_txn(1'b1, 1'b0, W'(1), W'(2), '0, '0, 0, 0);
        // Wrap-around
        run_txn(1'b0, 1'b1, '0, '0, ones, W'(1), 0, 0);
        run_txn(1'b0, 1'b1, '0, '0, half, half, 0, 0);
        // Arbitration with both requesters continuously valid
        for (int i = 0; i < 4; i++)
            run_txn(1'b1, 1'b1, rnd_op(), rnd_op(), rnd_op(), rnd_op(), 0, 0);
        // Transient dual-rail fault
        run_txn(1'b1, 1'b0, rnd_op(), rnd_op(), '0, '0, 1, 0);
        // Persistent fault, driving the error counter into saturation
        for (int i = 0; i < 300; i++)
            run_txn(1'b1, 1'b1, rnd_op(), rnd_op(), rnd_op(), rnd_op(), 2, 0);
        checkw("err_cnt_saturated", W'(err_cnt), W'(255));
        // Backpressure
        run_txn(1'b1, 1'b1, rnd_op(), rnd_op(), rnd_op(), rnd_op(), 0, 5);
        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            logic v0, v1;
            int   sel;
            sel = int'($urandom_range(1, 3));
            v0  = sel[0];
            v1  = sel[1];
            run_txn(v0, v1, rnd_op(), rnd_op(), rnd_op(), rnd_op(),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        // Reset while in ISSUE
        req0_valid = 1'b1; req0_a = rnd_op(); req0_b = rnd_op();
        @(negedge clk);
        req0_valid = 1'b0;
        check1("pre_rst_busy", req0_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_last   = 1;
        m_errcnt = 0;
        #1;
        check1("mid_rst_rsp_valid", rsp_valid, 1'b0);
        checkw("mid_rst_err_cnt", W'(err_cnt), '0);
        checkw("mid_rst_add_a", add_a, '0);
        @(negedge clk);
        check1("mid_rst_stays_idle", rsp_valid, 1'b0);
        run_txn(1'b1, 1'b1, rnd_op(), rnd_op(), rnd_op(), rnd_op(), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
